// File: rtl/load_store_unit_pkg.sv
// Shared control definitions for the load/store unit: op encodings, funct3 access widths,
// FSM states and the alignment rule.
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      OpNone  = 2'b00,
      OpLoad  = 2'b01,
      OpStore = 2'b10,
      OpRsvd  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StResp
   } state_e;

   // funct3[1:0] gives the access size; funct3[2] selects zero extension for loads
   localparam logic [1:0] SizeByte = 2'b00;
   localparam logic [1:0] SizeHalf = 2'b01;
   localparam logic [1:0] SizeWord = 2'b10;

   localparam logic [2:0] Funct3Lb  = 3'b000;
   localparam logic [2:0] Funct3Lh  = 3'b001;
   localparam logic [2:0] Funct3Lw  = 3'b010;
   localparam logic [2:0] Funct3Lbu = 3'b100;
   localparam logic [2:0] Funct3Lhu = 3'b101;

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
      logic ok;
      if (size == SizeByte) begin
         ok = 1'b1;
      end else if (size == SizeHalf) begin
         ok = ~offset[0];
      end else begin
         ok = (offset == 2'b00);
      end
      return ok;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the byte/half lane of a read word by address offset and sign- or zero-extends it.
module load_extend
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] lane;

   always_comb begin
      lane   = rdata_i >> {offset_i, 3'b000};
      data_o = lane;
      case (funct3_i)
         Funct3Lb:  data_o = {{24{lane[7]}}, lane[7:0]};
         Funct3Lh:  data_o = {{16{lane[15]}}, lane[15:0]};
         Funct3Lbu: data_o = {24'h0, lane[7:0]};
         Funct3Lhu: data_o = {16'h0, lane[15:0]};
         default:   data_o = lane;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE -> REQ -> RESP bus handshake with lane steering.
// Define LSU_TIMEOUT_EN to enable the response timeout (bus_err_o after TIMEOUT_CYCLES).
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        op_valid_i,
   input  logic [1:0]  op_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] load_data_o,
   output logic        done_o,
   output logic        busy_o,
   output logic        misaligned_o,
   output logic        bus_err_o
);

   state_e      state_q, state_d;
   logic        store_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q, data_q, load_data_q;
   logic        done_q, misaligned_q;
   logic        is_mem_op, aligned, accept, resp_ok, timeout;
   logic [31:0] ext_data, wdata;
   logic [3:0]  be;

   assign is_mem_op = op_valid_i && ((op_i == OpLoad) || (op_i == OpStore));
   assign aligned   = is_aligned(funct3_i[1:0], addr_i[1:0]);
   assign accept    = (state_q == StIdle) && is_mem_op && aligned;
   assign resp_ok   = (state_q == StResp) && mem_rvalid_i;

`ifdef LSU_TIMEOUT_EN
   logic [31:0] tmo_cnt_q;
   logic        bus_err_q;

   assign timeout = (state_q == StResp) && !mem_rvalid_i &&
                    (tmo_cnt_q >= (TIMEOUT_CYCLES - 32'd1));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tmo_cnt_q <= '0;
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= timeout;
         if ((state_q == StResp) && !mem_rvalid_i && !timeout) begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
         end else begin
            tmo_cnt_q <= '0;
         end
      end
   end

   assign bus_err_o = bus_err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout   = 1'b0;
   assign bus_err_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StReq;
         StReq:   if (mem_gnt_i) state_d = StResp;
         StResp:  if (mem_rvalid_i || timeout) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         store_q      <= 1'b0;
         funct3_q     <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         load_data_q  <= '0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         done_q       <= resp_ok;
         misaligned_q <= (state_q == StIdle) && is_mem_op && !aligned;
         if (accept) begin
            store_q  <= (op_i == OpStore);
            funct3_q <= funct3_i;
            addr_q   <= addr_i;
            data_q   <= store_data_i;
         end
         if (resp_ok && !store_q) begin
            load_data_q <= ext_data;
         end else if (timeout) begin
            load_data_q <= '0;
         end
      end
   end

   load_extend u_load_extend (
      .rdata_i  (mem_rdata_i),
      .offset_i (addr_q[1:0]),
      .funct3_i (funct3_q),
      .data_o   (ext_data)
   );

   // Narrow stores are replicated on every lane; byte enables pick the real one
   always_comb begin
      wdata = data_q;
      be    = 4'b1111;
      case (funct3_q[1:0])
         SizeByte: begin
            wdata = {4{data_q[7:0]}};
            be    = 4'b0001 << addr_q[1:0];
         end
         SizeHalf: begin
            wdata = {2{data_q[15:0]}};
            be    = 4'b0011 << addr_q[1:0];
         end
         default: begin
            wdata = data_q;
            be    = 4'b1111;
         end
      endcase
   end

   assign mem_req_o    = (state_q == StReq);
   assign mem_we_o     = (state_q == StReq) && store_q;
   assign mem_be_o     = (state_q == StReq) ? be : 4'b0000;
   assign mem_addr_o   = {addr_q[31:2], 2'b00};
   assign mem_wdata_o  = wdata;
   assign load_data_o  = load_data_q;
   assign done_o       = done_q;
   assign misaligned_o = misaligned_q;
   assign busy_o       = (state_q != StIdle) || accept;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        op_valid_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [2:0]  funct3_i = 3'b000;
   logic [31:0] addr_i = '0;
   logic [31:0] store_data_i = '0;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_req_o, mem_we_o, done_o, busy_o, misaligned_o, bus_err_o;
   logic [31:0] mem_addr_o, mem_wdata_o, load_data_o;
   logic [3:0]  mem_be_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_ld = '0;

   always #5 clk = ~clk;

   load_store_unit #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .op_valid_i   (op_valid_i),
      .op_i         (op_i),
      .funct3_i     (funct3_i),
      .addr_i       (addr_i),
      .store_data_i (store_data_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_be_o     (mem_be_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .load_data_o  (load_data_o),
      .done_o       (done_o),
      .busy_o       (busy_o),
      .misaligned_o (misaligned_o),
      .bus_err_o    (bus_err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference rules: half needs even address, word needs multiple of four
   function automatic logic model_aligned(input logic [2:0] f3, input logic [31:0] addr);
      if (f3 == 3'd1 || f3 == 3'd5) return (addr % 2) == 0;
      if (f3 == 3'd2) return (addr % 4) == 0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      logic [31:0] v;
      v = rdata >> (8 * (addr % 4));
      case (f3)
         3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
         3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
         3'd4: v = v & 32'hFF;
         3'd5: v = v & 32'hFFFF;
         default: v = rdata;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
      int n;
      n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      return ((32'd1 << n) - 32'd1) << (addr % 4);
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata);
      logic ok, is_st;
      ok    = model_aligned(f3, addr);
      is_st = (op == 2'b10);
      op_valid_i = 1'b1; op_i = op; funct3_i = f3; addr_i = addr; store_data_i = data;
      #1;
      check("busy_accept", 32'(busy_o), 32'(ok));
      step();
      op_valid_i = 1'b0; addr_i = $urandom; store_data_i = $urandom;
      check("misaligned", 32'(misaligned_o), 32'(!ok));
      if (!ok) begin
         check("misaligned_noreq", 32'(mem_req_o), 32'd0);
         check("misaligned_busy", 32'(busy_o), 32'd0);
         step();
         check("misaligned_clear", 32'(misaligned_o), 32'd0);
         check("misaligned_noreq2", 32'(mem_req_o), 32'd0);
         return;
      end
      for (int i = 0; i <= gnt_dly; i++) begin
         check("req", 32'(mem_req_o), 32'd1);
         check("req_addr", mem_addr_o, addr & ~32'h3);
         check("req_we", 32'(mem_we_o), 32'(is_st));
         check("req_busy", 32'(busy_o), 32'd1);
         if (is_st) begin
            check("req_be", 32'(mem_be_o), model_be(f3, addr));
            check("req_wdata", mem_wdata_o, model_wdata(f3, data));
         end
         mem_rvalid_i = 1'($urandom_range(0, 1));
         mem_rdata_i  = $urandom;
         mem_gnt_i    = (i == gnt_dly);
         step();
      end
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      for (int j = 0; j <= rv_dly; j++) begin
         check("resp_noreq", 32'(mem_req_o), 32'd0);
         check("resp_nodone", 32'(done_o), 32'd0);
         check("resp_busy", 32'(busy_o), 32'd1);
         mem_gnt_i    = 1'($urandom_range(0, 1));
         mem_rvalid_i = (j == rv_dly);
         mem_rdata_i  = (j == rv_dly) ? rdata : $urandom;
         step();
      end
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      if (!is_st) exp_ld = model_load(f3, addr, rdata);
      check("done", 32'(done_o), 32'd1);
      check("done_busy", 32'(busy_o), 32'd0);
      check("load_data", load_data_o, exp_ld);
      check("no_bus_err", 32'(bus_err_o), 32'd0);
      step();
      check("done_clear", 32'(done_o), 32'd0);
   endtask

   task automatic run_nop(input logic [1:0] op);
      op_valid_i = 1'b1; op_i = op; funct3_i = 3'($urandom_range(0, 7)); addr_i = $urandom;
      #1;
      check("nop_busy", 32'(busy_o), 32'd0);
      step();
      op_valid_i = 1'b0;
      check("nop_noreq", 32'(mem_req_o), 32'd0);
      check("nop_nomis", 32'(misaligned_o), 32'd0);
      check("nop_hold", load_data_o, exp_ld);
   endtask

   initial begin
      logic [2:0] ld_f3 [5];
      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      #1;
      check("rst_load_data", load_data_o, 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_req", 32'(mem_req_o), 32'd0);
      check("rst_we", 32'(mem_we_o), 32'd0);
      check("rst_be", 32'(mem_be_o), 32'd0);
      check("rst_mis", 32'(misaligned_o), 32'd0);
      check("rst_err", 32'(bus_err_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      step();
      step();
      reset_i = 1'b0;
      step();

      // LB sign-extension of top byte at minimum latency
      run_op(2'b01, 3'd0, 32'h1003, 32'h0, 0, 0, 32'h80FF_FF00);
      check("lb_value", load_data_o, 32'hFFFF_FF80);
      // SH to upper half
      run_op(2'b10, 3'd1, 32'h2002, 32'h0000_ABCD, 0, 0, 32'h0);
      // LW misaligned
      run_op(2'b01, 3'd2, 32'h1001, 32'h0, 0, 0, 32'h0);
      // grant withheld 5 cycles
      run_op(2'b10, 3'd2, 32'h4000_0010, 32'hDEAD_BEEF, 5, 1, 32'h0);
      run_op(2'b01, 3'd5, 32'h0000_0102, 32'h0, 5, 0, 32'h8765_4321);

      for (int n = 0; n < 60; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            run_nop(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11);
         end else if (kind >= 6) begin
            run_op(2'b10, 3'($urandom_range(0, 2)), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
         end else begin
            run_op(2'b01, ld_f3[$urandom_range(0, 4)], $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
         end
      end

      // Reset during RESP: response arriving afterwards must be dropped
      run_op(2'b01, 3'd2, 32'h0000_3000, 32'h0, 0, 0, 32'h1234_5678);
      op_valid_i = 1'b1; op_i = 2'b01; funct3_i = 3'd2; addr_i = 32'h3004;
      step();
      op_valid_i = 1'b0; mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0;
      check("pre_rst_busy", 32'(busy_o), 32'd1);
      reset_i = 1'b1;
      #1;
      check("rst_mid_busy", 32'(busy_o), 32'd0);
      check("rst_mid_load", load_data_o, 32'd0);
      check("rst_mid_req", 32'(mem_req_o), 32'd0);
      exp_ld = '0;
      step();
      reset_i = 1'b0;
      step();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
      step();
      mem_rvalid_i = 1'b0;
      check("rst_late_done", 32'(done_o), 32'd0);
      check("rst_late_load", load_data_o, 32'd0);
      check("rst_late_busy", 32'(busy_o), 32'd0);
      step();
      check("rst_late_done2", 32'(done_o), 32'd0);

      // Response never arrives
      op_valid_i = 1'b1; op_i = 2'b01; funct3_i = 3'd4; addr_i = 32'h5001;
      step();
      op_valid_i = 1'b0; mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0;
`ifdef LSU_TIMEOUT_EN
      for (int k = 0; k < 4; k++) begin
         check("tmo_wait_err", 32'(bus_err_o), 32'd0);
         check("tmo_wait_busy", 32'(busy_o), 32'd1);
         step();
      end
      check("tmo_err", 32'(bus_err_o), 32'd1);
      check("tmo_nodone", 32'(done_o), 32'd0);
      check("tmo_load", load_data_o, 32'd0);
      check("tmo_idle", 32'(busy_o), 32'd0);
      step();
      check("tmo_err_clear", 32'(bus_err_o), 32'd0);
`else
      for (int k = 0; k < 10; k++) begin
         check("wait_err", 32'(bus_err_o), 32'd0);
         check("wait_busy", 32'(busy_o), 32'd1);
         step();
      end
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_9A00;
      step();
      mem_rvalid_i = 1'b0;
      check("late_done", 32'(done_o), 32'd1);
      check("late_load", load_data_o, 32'h0000_009A);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
